// File: rtl/dfg_pkg.sv
// Shared types and the double-Feynman gate function used by the arbiter and its datapath.
package dfg_pkg;

  typedef logic [2:0] dfg_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } dfg_state_e;

  // {a,b,c} -> {a, a^b, a^c}; applying it twice returns the original vector.
  function automatic dfg_vec_t dfg_eval(input dfg_vec_t v);
    return {v[2], v[2] ^ v[1], v[2] ^ v[0]};
  endfunction

endpackage

// File: rtl/dfg_share_arbiter_if.sv
// Requester and response handshake bundle of the shared double-Feynman gate unit.
interface dfg_share_arbiter_if
  import dfg_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_abc;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  dfg_vec_t          rsp_pqr;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;

  // Clients and the consumer sit on the master side; the arbiter is the slave.
  modport master (
    output req_valid, req_abc, rsp_ready,
    input  req_ready, rsp_valid, rsp_pqr, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_abc, rsp_ready,
    output req_ready, rsp_valid, rsp_pqr, rsp_id, rsp_err
  );

endinterface

// File: rtl/dfg_core.sv
// Combinational double-Feynman gate; one instance serves both the forward and inverse pass.
module dfg_core
  import dfg_pkg::*;
(
  input  dfg_vec_t din,
  output dfg_vec_t dout
);

  assign dout = dfg_eval(din);

endmodule

// File: rtl/dfg_share_arbiter.sv
// Round-robin sharing of one double-Feynman gate among NREQ requesters, with an
// inverse self-check pass and saturating op/error counters.
module dfg_share_arbiter
  import dfg_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CW   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dfg_share_arbiter_if.slave  bus,
  input  logic                fault_inj,
  output logic [CW-1:0]       op_count,
  output logic [CW-1:0]       err_count
);

  localparam logic [CW-1:0]  CNT_MAX = '1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  dfg_state_e      state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_reg;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            found;
  logic            rsp_valid_q;
  logic            err_reg;
  logic [NREQ-1:0] grant;
  int              scan_sum;
  dfg_vec_t        abc_reg;
  dfg_vec_t        pqr_reg;
  dfg_vec_t        sel_abc;
  dfg_vec_t        core_in;
  dfg_vec_t        core_out;
  dfg_vec_t        chk;

  // Scan requesters starting at the round-robin pointer; grant only while IDLE.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    grant    = '0;
    winner   = '0;
    found    = 1'b0;
    cand     = '0;
    scan_sum = 0;
    if (state == IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_sum = int'(rr_ptr) + k;
        if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
        cand = IDW'(scan_sum);
        if (!found && bus.req_valid[cand]) begin
          found       = 1'b1;
          winner      = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_abc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_abc = bus.req_abc[3*i +: 3];
    end
  end

  // Forward pass evaluates the latched vector; inverse pass re-evaluates the result.
  assign core_in = (state == CHECK) ? pqr_reg : abc_reg;

  dfg_core u_core (
    .din  (core_in),
    .dout (core_out)
  );

  assign chk = core_out ^ {1'b0, fault_inj, 1'b0};

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_pqr   = pqr_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_err   = err_reg;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too because they drive visible response outputs.
      state       <= IDLE;
      rr_ptr      <= '0;
      abc_reg     <= '0;
      id_reg      <= '0;
      pqr_reg     <= '0;
      err_reg     <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_count    <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            abc_reg <= sel_abc;
            id_reg  <= winner;
            rr_ptr  <= (winner == LAST_ID) ? '0 : winner + 1'b1;
            state   <= EVAL;
          end
        end
        EVAL: begin
          pqr_reg <= core_out;
          state   <= CHECK;
        end
        CHECK: begin
          err_reg     <= (chk != abc_reg);
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
            if (op_count != CNT_MAX) op_count <= op_count + 1'b1;
            if (err_reg && err_count != CNT_MAX) err_count <= err_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfg_share_arbiter.sv
// Directed bench for dfg_share_arbiter: latency, vector sweep, round-robin order,
// back-pressure, fault injection, async reset and counter saturation.
module tb_dfg_share_arbiter;
  import dfg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic fault_inj = 1'b0;
  logic fault_inj2 = 1'b1;
  logic [7:0] op_count, err_count;
  logic [1:0] op_count2, err_count2;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ops  = 0;
  int exp_errs = 0;

  logic [2:0] sweep_exp [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                3'b111, 3'b110, 3'b101, 3'b100};
  logic [2:0] rr_abc [4] = '{3'b110, 3'b011, 3'b101, 3'b111};
  logic [2:0] rr_pqr [4] = '{3'b101, 3'b011, 3'b110, 3'b100};

  always #5 clk = ~clk;

  dfg_share_arbiter_if #(.NREQ(4), .IDW(2)) bus ();
  dfg_share_arbiter_if #(.NREQ(4), .IDW(2)) bus2 ();

  dfg_share_arbiter #(.NREQ(4), .IDW(2), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .fault_inj (fault_inj),
    .op_count  (op_count),
    .err_count (err_count)
  );

  dfg_share_arbiter #(.NREQ(4), .IDW(2), .CW(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2.slave),
    .fault_inj (fault_inj2),
    .op_count  (op_count2),
    .err_count (err_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vector from requester idx with the consumer always ready.
  task automatic run_one(input int idx, input logic [2:0] abc, input logic [2:0] exp_pqr,
                         input logic exp_err, input logic flt);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    bus.req_abc[3*idx +: 3] = abc;
    bus.req_valid = onehot;
    #1;
    check("grant", 32'(bus.req_ready), 32'(onehot));
    tick();
    bus.req_valid = '0;
    check("eval_no_grant", 32'(bus.req_ready), 32'(0));
    check("eval_no_rsp", 32'(bus.rsp_valid), 32'(0));
    tick();
    fault_inj = flt;
    tick();
    fault_inj = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(1));
    check("rsp_pqr", 32'(bus.rsp_pqr), 32'(exp_pqr));
    check("rsp_id", 32'(bus.rsp_id), 32'(idx));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    tick();
    if (exp_ops < 255) exp_ops++;
    if (exp_err && exp_errs < 255) exp_errs++;
    check("op_count", 32'(op_count), 32'(exp_ops));
    check("err_count", 32'(err_count), 32'(exp_errs));
    check("rsp_dropped", 32'(bus.rsp_valid), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    int   w;
    bus.req_valid  = '0;
    bus.req_abc    = '0;
    bus.rsp_ready  = 1'b1;
    bus2.req_valid = '0;
    bus2.req_abc   = '0;
    bus2.rsp_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp_pqr", 32'(bus.rsp_pqr), 32'(0));
    check("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    check("rst_rsp_err", 32'(bus.rsp_err), 32'(0));
    check("rst_op_count", 32'(op_count), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic latency case, then the full 8-vector sweep rotated over requesters.
    run_one(0, 3'b110, 3'b101, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) run_one(i % 4, 3'(i), sweep_exp[i], 1'b0, 1'b0);

    // All requesters pending: pointer is 0 after the sweep ended on requester 3.
    for (int r = 0; r < 4; r++) bus.req_abc[3*r +: 3] = rr_abc[r];
    bus.req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      w = g % 4;
      check("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << w));
      tick();
      check("rr_busy", 32'(bus.req_ready), 32'(0));
      tick();
      tick();
      check("rr_valid", 32'(bus.rsp_valid), 32'(1));
      check("rr_id", 32'(bus.rsp_id), 32'(w));
      check("rr_pqr", 32'(bus.rsp_pqr), 32'(rr_pqr[w]));
      tick();
      exp_ops++;
    end
    bus.req_valid = '0;
    #1;
    check("rr_op_count", 32'(op_count), 32'(exp_ops));
    check("idle_no_valid", 32'(bus.req_ready), 32'(0));

    // Back-pressure on requester 1 (pointer is 1 after last grant to 0).
    bus.req_abc[5:3] = 3'b001;
    bus.req_valid = 4'b0010;
    #1;
    check("stall_grant", 32'(bus.req_ready), 32'(4'b0010));
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(bus.rsp_valid), 32'(1));
      check("stall_pqr", 32'(bus.rsp_pqr), 32'(3'b001));
      check("stall_id", 32'(bus.rsp_id), 32'(1));
      check("stall_no_grant", 32'(bus.req_ready), 32'(0));
      check("stall_op_count", 32'(op_count), 32'(exp_ops));
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    exp_ops++;
    check("release_op_count", 32'(op_count), 32'(exp_ops));
    check("release_valid", 32'(bus.rsp_valid), 32'(0));
    tick();
    check("single_handshake", 32'(op_count), 32'(exp_ops));

    // Fault on the inverse pass of requester 2.
    run_one(2, 3'b101, 3'b110, 1'b1, 1'b1);

    // Async reset during EVAL; pointer is 3, so requester 2 wins by wrapping.
    bus.req_abc[8:6] = 3'b111;
    bus.req_valid = 4'b0100;
    #1;
    check("wrap_grant", 32'(bus.req_ready), 32'(4'b0100));
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    exp_ops  = 0;
    exp_errs = 0;
    check("arst_rsp_pqr", 32'(bus.rsp_pqr), 32'(0));
    check("arst_rsp_id", 32'(bus.rsp_id), 32'(0));
    check("arst_rsp_err", 32'(bus.rsp_err), 32'(0));
    check("arst_op_count", 32'(op_count), 32'(0));
    check("arst_err_count", 32'(err_count), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", 32'(seen), 32'(0));
    bus.req_valid = 4'b1111;
    #1;
    check("ptr_after_reset", 32'(bus.req_ready), 32'(4'b0001));
    bus.req_valid = '0;
    tick();

    // Two-bit counters with every op faulted saturate at 3.
    bus2.req_abc[2:0] = 3'b000;
    for (int k = 1; k <= 5; k++) begin
      bus2.req_valid = 4'b0001;
      tick();
      bus2.req_valid = '0;
      tick();
      tick();
      tick();
      check("sat_rsp_err", 32'(bus2.rsp_err), 32'(1));
      tick();
      check("sat_op_count", 32'(op_count2), 32'((k > 3) ? 3 : k));
      check("sat_err_count", 32'(err_count2), 32'((k > 3) ? 3 : k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
